// File: rtl/rtc_write_sequencer_if.sv
// Signal bundle between a requester and the RTC write sequencer.
// The master modport is the sequencer side, which drives the RTC bus.
interface rtc_write_sequencer_if;
  logic       start;
  logic [7:0] datos0, datos1, datos2, datos3, datos4, datos5,
              datos6, datos7, datos8, datos9, datos10;
  logic       busy, done, bus_oe, cs_n, wr_n, rd_n, AoD;
  logic [7:0] bus_out;

  modport master (
    input  start, datos0, datos1, datos2, datos3, datos4, datos5,
           datos6, datos7, datos8, datos9, datos10,
    output busy, done, bus_out, bus_oe, cs_n, wr_n, rd_n, AoD
  );
  modport slave (
    output start, datos0, datos1, datos2, datos3, datos4, datos5,
           datos6, datos7, datos8, datos9, datos10,
    input  busy, done, bus_out, bus_oe, cs_n, wr_n, rd_n, AoD
  );
endinterface

// File: rtl/rtc_write_sequencer.sv
// Writes the 11 RTC time/chrono registers as address/data pairs on the
// multiplexed bus with programmable setup, strobe and hold lengths.
module rtc_write_sequencer #(
  parameter int T_SU = 2,
  parameter int T_WR = 4,
  parameter int T_HD = 2
) (
  input  logic clk,
  input  logic reset,
  rtc_write_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, A_SU, A_WR, A_HD, D_SU, D_WR, D_HD, DONE} state_t;

  state_t           state, state_nx;
  logic [3:0]       cnt, cnt_nx;
  logic [3:0]       idx, idx_nx;
  logic [10:0][7:0] snap;
  logic             busy_nx, done_nx, oe_nx, cs_n_nx, wr_n_nx, aod_nx;
  logic [7:0]       bus_out_nx;

  // Counter holds remaining cycles minus one, so a state exits when it hits 0.
  function automatic logic [3:0] dur(state_t s);
    case (s)
      A_SU, D_SU: dur = 4'(T_SU - 1);
      A_WR, D_WR: dur = 4'(T_WR - 1);
      A_HD, D_HD: dur = 4'(T_HD - 1);
      default:    dur = 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] addr_of(logic [3:0] i);
    addr_of = (i < 4'd8) ? 8'h21 + {4'd0, i} : 8'h41 + {4'd0, i - 4'd8};
  endfunction

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    case (state)
      IDLE: if (bus.start) begin
        state_nx = A_SU;
        idx_nx   = 4'd0;
        cnt_nx   = dur(A_SU);
      end
      DONE: state_nx = IDLE;
      default: begin
        if (cnt != 4'd0) begin
          cnt_nx = cnt - 4'd1;
        end else begin
          case (state)
            A_SU:    state_nx = A_WR;
            A_WR:    state_nx = A_HD;
            A_HD:    state_nx = D_SU;
            D_SU:    state_nx = D_WR;
            D_WR:    state_nx = D_HD;
            default: begin
              if (idx == 4'd10) state_nx = DONE;
              else begin
                state_nx = A_SU;
                idx_nx   = idx + 4'd1;
              end
            end
          endcase
          cnt_nx = dur(state_nx);
        end
      end
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    busy_nx    = (state_nx != IDLE);
    done_nx    = (state_nx == DONE);
    oe_nx      = (state_nx != IDLE) && (state_nx != DONE);
    cs_n_nx    = !oe_nx;
    wr_n_nx    = !((state_nx == A_WR) || (state_nx == D_WR));
    aod_nx     = !((state_nx == D_SU) || (state_nx == D_WR) || (state_nx == D_HD));
    bus_out_nx = 8'h00;
    if (oe_nx) bus_out_nx = aod_nx ? addr_of(idx_nx) : snap[idx_nx];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      idx         <= 4'd0;
      snap        <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.bus_oe  <= 1'b0;
      bus.cs_n    <= 1'b1;
      bus.wr_n    <= 1'b1;
      bus.AoD     <= 1'b1;
      bus.bus_out <= 8'h00;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      idx         <= idx_nx;
      if (state == IDLE && bus.start)
        snap <= {bus.datos10, bus.datos9, bus.datos8, bus.datos7, bus.datos6, bus.datos5,
                 bus.datos4, bus.datos3, bus.datos2, bus.datos1, bus.datos0};
      bus.busy    <= busy_nx;
      bus.done    <= done_nx;
      bus.bus_oe  <= oe_nx;
      bus.cs_n    <= cs_n_nx;
      bus.wr_n    <= wr_n_nx;
      bus.AoD     <= aod_nx;
      bus.bus_out <= bus_out_nx;
    end
  end

  assign bus.rd_n = 1'b1;
endmodule

// File: doc/rtc_write_sequencer.md
RTC_WRITE_SEQUENCER -- requirements
Module: rtc_write_sequencer

Interface
REQ-001 The block SHALL have parameter T_SU, default 2, meaning cycles the bus is stable before the write strobe (legal range 1..15).
REQ-002 The block SHALL have parameter T_WR, default 4, meaning cycles wr_n is held low (legal range 1..15).
REQ-003 The block SHALL have parameter T_HD, default 2, meaning cycles the bus is held after wr_n rises (legal range 1..15).
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port start, input, 1 bit: request to write all 11 time/chrono registers.
REQ-007 Ports datos0..datos10, input, 8 bits each: values to write to RTC addresses 0x21..0x28 and 0x41..0x43, in that order.
REQ-008 Port busy, output, 1 bit: a sequence is in progress.
REQ-009 Port done, output, 1 bit: one-cycle pulse when the sequence completes.
REQ-010 Port bus_out, output, 8 bits: value driven onto the RTC multiplexed address/data bus.
REQ-011 Port bus_oe, output, 1 bit: bus output enable (1 = drive).
REQ-012 Port cs_n, output, 1 bit: RTC chip select, active low.
REQ-013 Port wr_n, output, 1 bit: RTC write strobe, active low.
REQ-014 Port rd_n, output, 1 bit: RTC read strobe, held at 1 by this block.
REQ-015 Port AoD, output, 1 bit: phase flag; 1 = address phase, 0 = data phase.

Function
REQ-016 States SHALL be IDLE, A_SU, A_WR, A_HD, D_SU, D_WR, D_HD and DONE.
REQ-017 In IDLE, start=1 at a rising edge SHALL latch datos0..datos10 into an internal snapshot, clear the transfer index to 0 and enter A_SU.
REQ-018 From that edge until DONE is left, the sequence SHALL use only the snapshot; input changes SHALL have no effect.
REQ-019 The address table SHALL be: index 0..7 -> 0x21..0x28, index 8..10 -> 0x41..0x43.
REQ-020 A_SU, A_WR and A_HD SHALL last T_SU, T_WR and T_HD cycles respectively, using one down-counter reloaded on each state entry.
REQ-021 In the A_* states: AoD=1 and bus_out = table address.
REQ-022 D_SU, D_WR and D_HD SHALL last T_SU, T_WR and T_HD cycles respectively.
REQ-023 In the D_* states: AoD=0 and bus_out = snapshot byte for the current index.
REQ-024 wr_n SHALL be 0 only in A_WR and D_WR; all other states drive wr_n=1.
REQ-025 cs_n=0, bus_oe=1 and busy=1 SHALL hold in all A_* and D_* states.
REQ-026 Transition order SHALL be A_SU -> A_WR -> A_HD -> D_SU -> D_WR -> D_HD.
REQ-027 At the end of D_HD: if index < 10, increment the index and go to A_SU; if index = 10, go to DONE (no wrap).
REQ-028 DONE SHALL last 1 cycle with done=1, busy=1, cs_n=1 and bus_oe=0, then go to IDLE.
REQ-029 In IDLE: busy=0, done=0, cs_n=1, wr_n=1, rd_n=1, bus_oe=0, AoD=1, bus_out=0x00.
REQ-030 start SHALL be ignored while busy=1, including in DONE; a start held high in IDLE after DONE SHALL begin a new sequence.
REQ-031 Each transfer SHALL take 2*(T_SU+T_WR+T_HD) cycles (16 with defaults); a full sequence holds busy high for 11*16+1 = 177 cycles with defaults.
REQ-032 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-033 reset=0 at a rising edge SHALL force IDLE, clear the index, counter and snapshot, and set the REQ-029 output values at that edge, including mid-transfer and during wr_n=0.
REQ-034 While reset=0, start SHALL be ignored; the first start accepted is at the first edge with reset=1.

Verification
REQ-035 Defaults; datos0..10 = 0x10..0x1A; start pulse -> eleven address/data pairs (0x21/0x10 ... 0x28/0x17, 0x41/0x18, 0x42/0x19, 0x43/0x1A), each wr_n low pulse exactly 4 cycles, done pulse 177 cycles after start.
REQ-036 Change datos3 to 0xFF one cycle after start -> data written at 0x24 remains 0x13.
REQ-037 Assert start again during transfer 5 -> no restart, order and length unchanged, exactly one done pulse.
REQ-038 Drive reset=0 during the second cycle of A_WR for 0x23 -> next edge wr_n=1, cs_n=1, bus_oe=0, busy=0; a later start begins again at 0x21.
REQ-039 Hold start high continuously -> back-to-back sequences separated by exactly one IDLE cycle after each done.
REQ-040 T_SU=1, T_WR=1, T_HD=1 -> 6 cycles per transfer; busy high for 67 cycles; a checker confirms bus_out and AoD are stable across every wr_n low interval.
